// File: rtl/gh_uart_fifo_pkg.sv
// Shared definitions for the UART FIFO controllers.
//   trig_sel_e     : encoding of the RX trigger-level select field
//   fifo_threshold : trigger threshold in words for a given select and address width
//   TO_CHAR_COUNT  : character times of inactivity before a receive timeout
package gh_uart_fifo_pkg;

  typedef enum logic [1:0] {
    TRIG_ONE       = 2'd0,
    TRIG_QUARTER   = 2'd1,
    TRIG_HALF      = 2'd2,
    TRIG_NEAR_FULL = 2'd3
  } trig_sel_e;

  localparam int unsigned TO_CHAR_COUNT = 4;

  function automatic int unsigned fifo_threshold(input logic [1:0] trig_sel,
                                                 input int unsigned add_width);
    int unsigned d;
    d = 32'd1 << add_width;
    case (trig_sel_e'(trig_sel))
      TRIG_ONE:     fifo_threshold = 1;
      TRIG_QUARTER: fifo_threshold = d / 4;
      TRIG_HALF:    fifo_threshold = d / 2;
      default:      fifo_threshold = d - 2;
    endcase
  endfunction

endpackage

// File: rtl/gh_gray2binary.sv
// Gray-code to binary converter, purely combinational.
//   size   : word width
//   i_gray : gray-coded input
//   o_bin  : binary equivalent (each bit is the XOR of all gray bits at or above it)
module gh_gray2binary #(
  parameter int size = 5
) (
  input  logic [size-1:0] i_gray,
  output logic [size-1:0] o_bin
);

  genvar i;
  generate
    for (i = 0; i < size; i++) begin : g_bit
      assign o_bin[i] = ^i_gray[size-1:i];
    end
  endgenerate

endmodule

// File: rtl/gh_rx_fifo_level_ctrl.sv
// Read-side controller of the UART RX FIFO: tracks the read pointer against the
// already-synchronized gray write pointer, produces level/empty/full, and raises
// the trigger-level and character-timeout interrupts.
// Optional feature macro: GH_RX_FIFO_TIMEOUT_EN (timeout counter and o_to_irq;
// when undefined o_to_irq is tied low and i_to_tick is ignored).
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_wr_ptr_g     : gray write pointer (add_width+1 bits)
//   i_rd_req       : consumer read request
//   i_flush        : discard contents
//   i_trig_sel     : trigger level select
//   i_to_tick      : one pulse per character time
//   o_rd_en        : RAM read strobe
//   o_rd_addr      : RAM read address
//   o_level        : occupancy 0..D
//   o_empty/o_full : level == 0 / level == D
//   o_trig_irq     : level at or above the selected threshold
//   o_to_irq       : character timeout
//   o_ovf_err      : sticky, occupancy computed above D
module gh_rx_fifo_level_ctrl
  import gh_uart_fifo_pkg::*;
#(
  parameter int add_width = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [add_width:0]   i_wr_ptr_g,
  input  logic                 i_rd_req,
  input  logic                 i_flush,
  input  logic [1:0]           i_trig_sel,
  input  logic                 i_to_tick,
  output logic                 o_rd_en,
  output logic [add_width-1:0] o_rd_addr,
  output logic [add_width:0]   o_level,
  output logic                 o_empty,
  output logic                 o_full,
  output logic                 o_trig_irq,
  output logic                 o_to_irq,
  output logic                 o_ovf_err
);

  localparam int PW = add_width + 1;
  localparam logic [PW-1:0] DEPTH = PW'(1 << add_width);

  logic [PW-1:0] r_wr_g_q, r_rd_ptr, r_level;
  logic [PW-1:0] w_wr_b, w_rd_ptr_nx, w_diff, w_thr;
  logic          r_trig, r_ovf, w_rd_en, w_empty;

  gh_gray2binary #(.size(PW)) u_g2b (
    .i_gray (r_wr_g_q),
    .o_bin  (w_wr_b)
  );

  assign w_empty     = (r_level == '0);
  assign w_rd_en     = i_rd_req & ~w_empty & ~i_flush;
  assign w_rd_ptr_nx = r_rd_ptr + PW'(w_rd_en);
  // Level is computed against the post-read pointer so a read is reflected at
  // the same edge that consumes the word.
  assign w_diff      = w_wr_b - w_rd_ptr_nx;
  assign w_thr       = PW'(fifo_threshold(i_trig_sel, add_width));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_g_q <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_trig   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_wr_g_q <= i_wr_ptr_g;
      r_trig   <= (r_level >= w_thr);
      if (i_flush) begin
        r_rd_ptr <= w_wr_b;
        r_level  <= '0;
        r_ovf    <= 1'b0;
      end else begin
        r_rd_ptr <= w_rd_ptr_nx;
        // A difference above D can only come from a corrupted write pointer.
        if (w_diff > DEPTH) begin
          r_level <= DEPTH;
          r_ovf   <= 1'b1;
        end else begin
          r_level <= w_diff;
        end
      end
    end
  end

`ifdef GH_RX_FIFO_TIMEOUT_EN
  logic [2:0] r_to_cnt, w_to_cnt_nx;
  logic       r_to_irq, w_to_clr, w_wr_chg;

  // The write pointer register is about to take a new value: a word arrived.
  assign w_wr_chg = (i_wr_ptr_g != r_wr_g_q);
  assign w_to_clr = w_rd_en | i_flush | w_wr_chg;

  always_comb begin
    w_to_cnt_nx = r_to_cnt;
    if (w_to_clr || r_level == '0)
      w_to_cnt_nx = '0;
    else if (i_to_tick && r_to_cnt < 3'(TO_CHAR_COUNT))
      w_to_cnt_nx = r_to_cnt + 3'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_to_cnt <= '0;
      r_to_irq <= 1'b0;
    end else begin
      r_to_cnt <= w_to_cnt_nx;
      // w_to_cnt_nx is forced to 0 on an empty FIFO, so reaching the limit
      // implies pending data.
      if (w_to_clr)
        r_to_irq <= 1'b0;
      else if (w_to_cnt_nx == 3'(TO_CHAR_COUNT))
        r_to_irq <= 1'b1;
    end
  end

  assign o_to_irq = r_to_irq;
`else
  logic w_unused_to_tick;
  assign w_unused_to_tick = i_to_tick;
  assign o_to_irq         = 1'b0;
`endif

  assign o_rd_en    = w_rd_en;
  assign o_rd_addr  = r_rd_ptr[add_width-1:0];
  assign o_level    = r_level;
  assign o_empty    = w_empty;
  assign o_full     = (r_level == DEPTH);
  assign o_trig_irq = r_trig;
  assign o_ovf_err  = r_ovf;

endmodule

// File: tb/tb_gh_rx_fifo_level_ctrl.sv
// Directed bench for gh_rx_fifo_level_ctrl (add_width = 4, D = 16).
module tb_gh_rx_fifo_level_ctrl;

`ifdef GH_RX_FIFO_TIMEOUT_EN
  localparam logic EXP_TO = 1'b1;
`else
  localparam logic EXP_TO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] wr_ptr_g;
  logic       rd_req, flush, to_tick;
  logic [1:0] trig_sel;
  logic       rd_en, empty, full, trig_irq, to_irq, ovf_err;
  logic [3:0] rd_addr;
  logic [4:0] level;

  int n_assert = 0;
  int n_fail   = 0;
  int wp       = 0;
  int cnt;

  always #5 clk = ~clk;

  gh_rx_fifo_level_ctrl #(.add_width(4)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_wr_ptr_g (wr_ptr_g),
    .i_rd_req   (rd_req),
    .i_flush    (flush),
    .i_trig_sel (trig_sel),
    .i_to_tick  (to_tick),
    .o_rd_en    (rd_en),
    .o_rd_addr  (rd_addr),
    .o_level    (level),
    .o_empty    (empty),
    .o_full     (full),
    .o_trig_irq (trig_irq),
    .o_to_irq   (to_irq),
    .o_ovf_err  (ovf_err)
  );

  function automatic logic [4:0] gray(input int v);
    logic [4:0] b;
    b = v[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // From one negedge to the next, crossing exactly one rising edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr_step();
    wp       = (wp + 1) % 32;
    wr_ptr_g = gray(wp);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; wr_ptr_g = '0; rd_req = 1'b0; flush = 1'b0;
    trig_sel = 2'd3; to_tick = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_trig", trig_irq, 0);
    chk("rst_to", to_irq, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_rden", rd_en, 0);
    chk("rst_addr", rd_addr, 0);
    rst_n = 1'b1;
    tick();

    // Fill 0..16: level lags the gray step by one edge, trig_irq by two
    for (int k = 1; k <= 16; k++) begin
      wr_step();
      if (k == 8)  chk("fill_level_mid", level, 7);
      if (k == 15) chk("fill_trig_below", trig_irq, 0);
      if (k == 16) chk("fill_trig_at14", trig_irq, 1);
    end
    tick();
    chk("fill_level16", level, 16);
    chk("fill_full", full, 1);
    chk("fill_empty", empty, 0);

    // Drain all 16 back to back
    rd_req = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      if (k == 0 || k == 15) begin
        chk("drain_rden", rd_en, 1);
        chk("drain_addr", rd_addr, k);
      end
      tick();
    end
    rd_req = 1'b0;
    chk("drain_level", level, 0);
    chk("drain_empty", empty, 1);
    chk("drain_full", full, 0);

    // Move read pointer to 31
    repeat (15) wr_step();
    tick();
    rd_req = 1'b1;
    repeat (15) tick();
    rd_req = 1'b0;
    chk("pre_level", level, 0);

    // Write 3 across the 31->0 wrap, then read them back
    repeat (3) wr_step();
    tick();
    chk("wrap_level3", level, 3);
    rd_req = 1'b1;
    #1 chk("wrap_addr15", rd_addr, 15);
    tick();
    #1 chk("wrap_addr0", rd_addr, 0);
    tick();
    #1 chk("wrap_addr1", rd_addr, 1);
    tick();
    rd_req = 1'b0;
    chk("wrap_level0", level, 0);
    chk("wrap_empty", empty, 1);
    chk("wrap_ovf", ovf_err, 0);

    // Read request held 3 cycles with one word present
    wr_step();
    tick();
    chk("one_level", level, 1);
    cnt = 0;
    rd_req = 1'b1;
    repeat (3) begin
      #1 if (rd_en) cnt++;
      tick();
    end
    rd_req = 1'b0;
    chk("one_rden_cnt", cnt, 1);
    chk("one_empty", empty, 1);

    // Timeout with two words pending
    repeat (2) wr_step();
    tick();
    chk("to_level2", level, 2);
    to_tick = 1'b1;
    repeat (3) tick();
    chk("to_after3", to_irq, 0);
    tick();
    to_tick = 1'b0;
    chk("to_after4", to_irq, EXP_TO);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("to_rd_clr", to_irq, 0);
    chk("to_rd_level", level, 1);

    // Flush with 5 pending, read request in the same cycle
    repeat (4) wr_step();
    tick();
    chk("fl_level5", level, 5);
    to_tick = 1'b1;
    repeat (4) tick();
    to_tick = 1'b0;
    chk("fl_to_set", to_irq, EXP_TO);
    flush = 1'b1; rd_req = 1'b1;
    #1 chk("fl_rden", rd_en, 0);
    tick();
    flush = 1'b0; rd_req = 1'b0;
    chk("fl_level", level, 0);
    chk("fl_empty", empty, 1);
    chk("fl_to_clr", to_irq, 0);

    // Illegal gray jump: rd_ptr 9, wr 29 -> 20 words computed
    wp = 29;
    wr_ptr_g = gray(wp);
    tick();
    tick();
    chk("ovf_level", level, 16);
    chk("ovf_set", ovf_err, 1);
    chk("ovf_full", full, 1);
    tick();
    chk("ovf_sticky", ovf_err, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("ovf_clr", ovf_err, 0);
    chk("ovf_fl_level", level, 0);

    // Trigger at 1 word, simultaneous read + write, then async reset
    trig_sel = 2'd0;
    repeat (3) wr_step();
    tick();
    tick();
    chk("mid_trig", trig_irq, 1);
    wp = (wp + 1) % 32;
    wr_ptr_g = gray(wp);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    tick();
    chk("rw_level", level, 3);
    rst_n = 1'b0;
    #1;
    chk("arst_level", level, 0);
    chk("arst_empty", empty, 1);
    chk("arst_trig", trig_irq, 0);
    chk("arst_addr", rd_addr, 0);
    chk("arst_to", to_irq, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
